// File: rtl/pc_pkg.sv
// Shared types, counter encodings and helpers for the fetch-stage PC predictor.
package pc_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'b00;
    localparam ctr_t CTR_WNT = 2'b01;
    localparam ctr_t CTR_WT  = 2'b10;
    localparam ctr_t CTR_ST  = 2'b11;

    localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;

    // Two-bit saturating counter step toward the resolved direction.
    function automatic ctr_t sat_update(input ctr_t ctr, input logic taken);
        ctr_t res;
        res = ctr;
        if (taken && (ctr != CTR_ST)) begin
            res = ctr + 2'd1;
        end else if (!taken && (ctr != CTR_SNT)) begin
            res = ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/pc_predict_btb_dm.sv
// Direct-mapped branch target buffer: combinational lookup port, clocked training port.
module btb_dm
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned BTB_ENTRIES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:2] rd_pc_i,
    output logic             pred_taken_o,
    output logic [WIDTH-1:0] pred_target_o,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:2] wr_pc_i,
    input  logic             wr_taken_i,
    input  logic [WIDTH-1:2] wr_target_i
);

    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = WIDTH - IDX_W - 2;

    logic [BTB_ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]       tag_q [BTB_ENTRIES];
    logic [WIDTH-1:2]       tgt_q [BTB_ENTRIES];
    ctr_t                   ctr_q [BTB_ENTRIES];

    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic             rd_hit;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] wr_tag;
    logic             wr_hit;
    ctr_t             ctr_d;

    assign rd_idx = rd_pc_i[IDX_W+1:2];
    assign rd_tag = rd_pc_i[WIDTH-1:IDX_W+2];
    assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);

    assign pred_taken_o  = rd_hit && ctr_q[rd_idx][1];
    assign pred_target_o = pred_taken_o ? {tgt_q[rd_idx], 2'b00} : '0;

    assign wr_idx = wr_pc_i[IDX_W+1:2];
    assign wr_tag = wr_pc_i[WIDTH-1:IDX_W+2];
    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
    assign ctr_d  = sat_update(ctr_q[wr_idx], wr_taken_i);

    // Training: hits step the counter, taken misses allocate, not-taken misses are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= CTR_WNT;
            end
        end else if (wr_en_i) begin
            if (wr_hit) begin
                ctr_q[wr_idx] <= ctr_d;
                if (wr_taken_i) begin
                    tgt_q[wr_idx] <= wr_target_i;
                end
            end else if (wr_taken_i) begin
                valid_q[wr_idx] <= 1'b1;
                tag_q[wr_idx]   <= wr_tag;
                tgt_q[wr_idx]   <= wr_target_i;
                ctr_q[wr_idx]   <= CTR_WT;
            end
        end
    end

endmodule

// File: rtl/pc_predict.sv
// Fetch PC register with redirect/stall/prediction next-PC selection and a BTB predictor.
module pc_predict
    import pc_pkg::*;
#(
    parameter int unsigned      WIDTH        = 32,
    parameter int unsigned      BTB_ENTRIES  = 16,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             ex_redirect,
    input  logic [WIDTH-1:0] ex_redirect_pc,
    input  logic             ex_update,
    input  logic [WIDTH-1:0] ex_pc,
    input  logic             ex_taken,
    input  logic [WIDTH-1:0] ex_target,
    output logic [WIDTH-1:0] PC_out,
    output logic [WIDTH-1:0] PC_Plus4,
    output logic             pred_taken,
    output logic [WIDTH-1:0] pred_target
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_plus4;
    logic             unused_low_bits;

    // Low address bits are always forced to zero, so these inputs bits carry no information.
    assign unused_low_bits = ^{ex_redirect_pc[1:0], ex_pc[1:0], ex_target[1:0]};

    assign pc_plus4 = pc_q + WIDTH'(4);
    assign PC_out   = pc_q;
    assign PC_Plus4 = pc_plus4;

    btb_dm #(
        .WIDTH       (WIDTH),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk           (clk),
        .rst           (rst),
        .rd_pc_i       (pc_q[WIDTH-1:2]),
        .pred_taken_o  (pred_taken),
        .pred_target_o (pred_target),
        .wr_en_i       (ex_update),
        .wr_pc_i       (ex_pc[WIDTH-1:2]),
        .wr_taken_i    (ex_taken),
        .wr_target_i   (ex_target[WIDTH-1:2])
    );

    // Redirect beats stall, stall beats prediction, prediction beats sequential fetch.
    always_comb begin
        pc_d = pc_plus4;
        if (ex_redirect) begin
            pc_d = {ex_redirect_pc[WIDTH-1:2], 2'b00};
        end else if (stall) begin
            pc_d = pc_q;
        end else if (pred_taken) begin
            pc_d = pred_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= {RESET_VECTOR[WIDTH-1:2], 2'b00};
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_pc_predict.sv
// Directed, table-driven bench for pc_predict with hand-computed expectations.
module tb_pc_predict;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        ex_redirect;
    logic [31:0] ex_redirect_pc;
    logic        ex_update;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic [31:0] PC_out;
    logic [31:0] PC_Plus4;
    logic        pred_taken;
    logic [31:0] pred_target;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        upd;
        logic [31:0] epc;
        logic        tkn;
        logic [31:0] etgt;
        logic [31:0] exp_pc;
        logic        exp_pred;
        logic [31:0] exp_tgt;
    } vec_t;

    vec_t vq[$];

    pc_predict #(
        .WIDTH       (32),
        .BTB_ENTRIES (16),
        .RESET_VECTOR(32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .ex_redirect    (ex_redirect),
        .ex_redirect_pc (ex_redirect_pc),
        .ex_update      (ex_update),
        .ex_pc          (ex_pc),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .PC_out         (PC_out),
        .PC_Plus4       (PC_Plus4),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic r, input logic [31:0] rpc,
                       input logic u, input logic [31:0] epc, input logic t,
                       input logic [31:0] etgt, input logic [31:0] xpc,
                       input logic xpred, input logic [31:0] xtgt);
        vec_t v;
        v.stall = s; v.redir = r; v.rpc = rpc; v.upd = u; v.epc = epc;
        v.tkn = t; v.etgt = etgt; v.exp_pc = xpc; v.exp_pred = xpred; v.exp_tgt = xtgt;
        vq.push_back(v);
    endtask

    task automatic idle_inputs();
        stall = 1'b0; ex_redirect = 1'b0; ex_redirect_pc = '0;
        ex_update = 1'b0; ex_pc = '0; ex_taken = 1'b0; ex_target = '0;
    endtask

    initial begin
        logic prev_pred;
        rst = 1'b1;
        idle_inputs();

        // Sequential walk from reset: 4*i, never predicted (includes 0x20 and 0x30).
        for (int i = 1; i <= 13; i++) add(0, 0, 0, 0, 0, 0, 0, 32'(4 * i), 0, 0);
        // Stall hold, release, redirect overriding stall.
        add(0, 1, 32'h10, 0, 0, 0, 0, 32'h10, 0, 0);
        for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 0, 0, 32'h10, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 32'h14, 0, 0);
        add(1, 1, 32'h80, 0, 0, 0, 0, 32'h80, 0, 0);
        // Allocate taken entry at 0x20 -> 0x100, then fetch it.
        add(0, 0, 0, 1, 32'h20, 1, 32'h100, 32'h84, 0, 0);
        add(0, 1, 32'h20, 0, 0, 0, 0, 32'h20, 1, 32'h100);
        add(0, 0, 0, 0, 0, 0, 0, 32'h100, 0, 0);
        // Counter walk while fetch is stalled at 0x20.
        add(0, 1, 32'h20, 0, 0, 0, 0, 32'h20, 1, 32'h100);
        for (int i = 0; i < 3; i++) add(1, 0, 0, 1, 32'h20, 0, 0, 32'h20, 0, 0);
        add(1, 0, 0, 1, 32'h20, 1, 32'h100, 32'h20, 0, 0);
        add(1, 0, 0, 1, 32'h20, 1, 32'h100, 32'h20, 1, 32'h100);
        add(1, 0, 0, 1, 32'h20, 1, 32'h100, 32'h20, 1, 32'h100);
        add(1, 0, 0, 1, 32'h20, 1, 32'h140, 32'h20, 1, 32'h140);
        add(1, 0, 0, 1, 32'h20, 0, 0, 32'h20, 1, 32'h140);
        add(1, 0, 0, 1, 32'h20, 0, 0, 32'h20, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 32'h24, 0, 0);
        // Alias at 0x60 with simultaneous redirect+update; not-taken alias leaves 0x20 alone.
        add(0, 1, 32'h60, 1, 32'h20, 1, 32'h140, 32'h60, 0, 0);
        add(1, 0, 0, 1, 32'h60, 0, 0, 32'h60, 0, 0);
        add(0, 1, 32'h20, 0, 0, 0, 0, 32'h20, 1, 32'h140);
        add(0, 0, 0, 0, 0, 0, 0, 32'h140, 0, 0);
        // Not-taken miss allocates nothing.
        add(1, 0, 0, 1, 32'h300, 0, 32'h500, 32'h140, 0, 0);
        add(0, 1, 32'h300, 0, 0, 0, 0, 32'h300, 0, 0);
        // Stored target is aligned.
        add(0, 0, 0, 1, 32'h40, 1, 32'h203, 32'h304, 0, 0);
        add(0, 1, 32'h40, 0, 0, 0, 0, 32'h40, 1, 32'h200);
        add(0, 0, 0, 0, 0, 0, 0, 32'h200, 0, 0);
        // Wraparound and redirect alignment.
        add(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        add(0, 1, 32'h103, 0, 0, 0, 0, 32'h100, 0, 0);

        // Run briefly, train 0x30 -> 0x200, then assert reset mid-cycle.
        #12 rst = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        ex_update = 1'b1; ex_pc = 32'h30; ex_taken = 1'b1; ex_target = 32'h200;
        @(posedge clk); #1;
        idle_inputs();
        chk("pre_reset_pc", PC_out, 32'hC);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_pc", PC_out, 32'h0);
        chk("async_reset_pred", 32'(pred_taken), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_pc", PC_out, 32'h0);
        chk("reset_plus4", PC_Plus4, 32'h4);
        chk("reset_pred", 32'(pred_taken), 32'h0);

        prev_pred = 1'b0;
        for (int i = 0; i < vq.size(); i++) begin
            stall          = vq[i].stall;
            ex_redirect    = vq[i].redir;
            ex_redirect_pc = vq[i].rpc;
            ex_update      = vq[i].upd;
            ex_pc          = vq[i].epc;
            ex_taken       = vq[i].tkn;
            ex_target      = vq[i].etgt;
            #1;
            chk($sformatf("v%0d_pre_edge_pred", i), 32'(pred_taken), 32'(prev_pred));
            @(posedge clk); #1;
            chk($sformatf("v%0d_pc", i), PC_out, vq[i].exp_pc);
            chk($sformatf("v%0d_plus4", i), PC_Plus4, vq[i].exp_pc + 32'd4);
            chk($sformatf("v%0d_pred", i), 32'(pred_taken), 32'(vq[i].exp_pred));
            if (vq[i].exp_pred) chk($sformatf("v%0d_tgt", i), pred_target, vq[i].exp_tgt);
            prev_pred = vq[i].exp_pred;
        end
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
